// File: rtl/x_23k640_resp_pkg.sv
// Shared definitions for the 23K640 SPI SRAM responder: opcodes, mode
// encodings and the transfer FSM state type.
package x_23K640_pkg;

  localparam logic [7:0] INS_READ  = 8'h03;
  localparam logic [7:0] INS_WRITE = 8'h02;
  localparam logic [7:0] INS_RDSR  = 8'h05;
  localparam logic [7:0] INS_WRSR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_RDSR,
    ST_WRSR,
    ST_IGNORE
  } state_e;

  // Page and sequential modes keep streaming; 00 and 11 stop after one byte.
  function automatic logic is_stream_mode(input logic [1:0] mode);
    return (mode == MODE_PAGE) || (mode == MODE_SEQ);
  endfunction

endpackage

// File: rtl/x_23k640_resp_sync.sv
// Brings SCK/CS/SI into the i_clk domain and derives one-cycle SCK edge
// strobes from the registered synchronised clock.
module x_23K640_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sck,
  input  logic i_cs,
  input  logic i_si,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_n_o,
  output logic si_o
);

  logic [1:0] sck_q;
  logic [1:0] cs_q;
  logic [1:0] si_q;
  logic       sck_dly_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sck_q     <= '0;
      cs_q      <= '1;
      si_q      <= '0;
      sck_dly_q <= 1'b0;
    end else begin
      sck_q     <= {sck_q[0], i_sck};
      cs_q      <= {cs_q[0], i_cs};
      si_q      <= {si_q[0], i_si};
      sck_dly_q <= sck_q[1];
    end
  end

  assign sck_rise_o = sck_q[1] & ~sck_dly_q;
  assign sck_fall_o = ~sck_q[1] & sck_dly_q;
  assign cs_n_o     = cs_q[1];
  assign si_o       = si_q[1];

endmodule

// File: rtl/x_23k640_resp.sv
// 23K640 SPI SRAM responder: decodes READ/WRITE/RDSR/WRSR from an SPI mode-0
// initiator and services them against an external synchronous RAM.
module x_23k640_resp
  import x_23K640_pkg::*;
#(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned PAGE_W     = 5,
  parameter logic [7:0]  STATUS_RST = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_cs,
  input  logic              i_si,
  output logic              o_so,
  output logic              o_so_oe,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  output logic [7:0]        o_status
);

  logic sck_rise, sck_fall, cs_n, si;

  x_23K640_sync u_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_sck     (i_sck),
    .i_cs      (i_cs),
    .i_si      (i_si),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .cs_n_o    (cs_n),
    .si_o      (si)
  );

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          sh_q, sh_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [7:0]          out_q, out_d;
  logic                oe_q, oe_d;
  logic [7:0]          status_q, status_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                rd_wait_q, rd_wait_d;
  logic                rd_load_q, rd_load_d;
  logic [7:0]          byte_in;
  logic [ADDR_W-1:0]   addr_in;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                stream;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        mode);
    logic [ADDR_W-1:0] n;
    n = a + ADDR_W'(1);
    if (mode == MODE_PAGE) n = {a[ADDR_W-1:PAGE_W], n[PAGE_W-1:0]};
    return n;
  endfunction

  assign byte_in  = {sh_q[6:0], si};
  assign addr_in  = {addr_q[ADDR_W-2:0], si};
  assign addr_nxt = next_addr(addr_q, status_q[7:6]);
  assign stream   = is_stream_mode(status_q[7:6]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    out_d       = out_q;
    oe_d        = oe_q;
    status_d    = status_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_wait_d   = 1'b0;
    rd_load_d   = rd_wait_q;

    if (cs_n) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      oe_d      = 1'b0;
      out_d     = '0;
      rd_load_d = 1'b0;
    end else begin
      if (sck_rise) sh_d = byte_in;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end
        ST_CMD: if (sck_rise) begin
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            case (byte_in)
              INS_READ:  begin state_d = ST_ADDR; wr_d = 1'b0; end
              INS_WRITE: begin state_d = ST_ADDR; wr_d = 1'b1; end
              INS_RDSR:  begin state_d = ST_RDSR; out_d = status_q; oe_d = 1'b1; end
              INS_WRSR:  state_d = ST_WRSR;
              default:   state_d = ST_IGNORE;
            endcase
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_ADDR: if (sck_rise) begin
          addr_d = addr_in;
          if (cnt_q == 4'd15) begin
            cnt_d = '0;
            if (wr_q) begin
              state_d = ST_WR_DATA;
            end else begin
              state_d    = ST_RD_DATA;
              mem_en_d   = 1'b1;
              mem_addr_d = addr_in;
              rd_wait_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_WR_DATA: if (sck_rise) begin
          if (cnt_q == 4'd7) begin
            cnt_d       = '0;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = byte_in;
            addr_d      = addr_nxt;
            if (!stream) state_d = ST_IGNORE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_WRSR: if (sck_rise) begin
          if (cnt_q == 4'd7) begin
            status_d = {byte_in[7:6], 6'b0};
            state_d  = ST_IGNORE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_RD_DATA, ST_RDSR: begin
          // cnt counts rises of the current byte; a fall only shifts once a
          // rise has been seen, so the tail of the header bit is skipped.
          if (state_q == ST_RD_DATA && rd_load_q) begin
            out_d = i_mem_rdata;
            oe_d  = 1'b1;
          end
          if (sck_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (sck_fall && cnt_q != 4'd0) begin
            if (cnt_q == 4'd8) begin
              cnt_d = '0;
              if (state_q == ST_RDSR) begin
                out_d = status_q;
              end else if (stream) begin
                addr_d     = addr_nxt;
                mem_en_d   = 1'b1;
                mem_addr_d = addr_nxt;
                rd_wait_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
                oe_d    = 1'b0;
              end
            end else begin
              out_d = {out_q[6:0], 1'b0};
            end
          end
        end
        ST_IGNORE: oe_d = 1'b0;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      out_q       <= '0;
      oe_q        <= 1'b0;
      status_q    <= STATUS_RST;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_wait_q   <= 1'b0;
      rd_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      status_q    <= status_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_wait_q   <= rd_wait_d;
      rd_load_q   <= rd_load_d;
    end
  end

  assign o_so        = oe_q & out_q[7];
  assign o_so_oe     = oe_q;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_status    = status_q;

endmodule

// File: doc/x_23k640_resp.md
Name: x_23K640_resp

Overview:
SPI responder emulating the 23K640 SPI SRAM (slave end of the SPI link).
- Decodes READ, WRITE, RDSR and WRSR instructions from an SPI initiator.
- Services them against an external synchronous single-port RAM.
- Serves as a synthesizable bench/FPGA stand-in for the physical SRAM, so the SRAM controller can be exercised in closed loop.

Parameters:
- ADDR_W, 13, implemented address bits; the upper 16-ADDR_W bits of the received address are ignored.
- PAGE_W, 5, page-offset bits for page mode (32-byte page).
- STATUS_RST, 8'h00, status register reset value (byte mode).

Ports:
- i_clk  in  1  system clock; must be at least 8x the SCK frequency.
- i_rst  in  1  reset, asynchronous, active-high.
- i_sck  in  1  SPI clock from initiator (mode 0), asynchronous to i_clk.
- i_cs  in  1  chip select, active-low.
- i_si  in  1  serial data from initiator.
- o_so  out  1  serial data to initiator.
- o_so_oe  out  1  SO output enable (high only while shifting read/status data).
- o_mem_en  out  1  RAM access strobe, one i_clk pulse.
- o_mem_we  out  1  RAM write enable, qualified by o_mem_en.
- o_mem_addr  out  ADDR_W  RAM address.
- o_mem_wdata  out  8  RAM write data.
- i_mem_rdata  in  8  RAM read data, valid 1 cycle after o_mem_en with o_mem_we=0.
- o_status  out  8  current status register.

Behaviour:
- Reset: all outputs 0, status = STATUS_RST, FSM = IDLE, counters 0. Reset mid-transfer aborts with no RAM write.
- Input sync: i_sck, i_cs, i_si each pass through a 2-flop synchronizer. Rise/fall strobes come from the registered synced SCK.
- Sampling: SI is sampled on SCK rise, MSB first. SO changes on SCK fall.
- The first read bit is driven within 4 i_clk of the CS assert or the last address-bit rise.
- CS deasserted (synced high) in any state: FSM -> IDLE on the next i_clk, o_so_oe=0, partial byte discarded. This takes priority over a simultaneous SCK edge.
- FSM states:
  - IDLE: on CS low -> CMD, bit count 0.
  - CMD: after 8 bits, decode the byte:
    - 0x03 -> ADDR (read)
    - 0x02 -> ADDR (write)
    - 0x05 -> RDSR
    - 0x01 -> WRSR
    - any other -> IGNORE
  - ADDR: shift 16 bits. On the 16th rise:
    - read: issue RAM read -> RD_DATA
    - write: -> WR_DATA
  - RD_DATA: load the shift register from i_mem_rdata before the next fall. Drive 8 bits. On the 8th fall of each byte, advance the address and prefetch the next byte. Repeats until CS high.
  - WR_DATA: on each 8th rise, pulse o_mem_en/o_mem_we with the assembled byte, then advance the address.
  - RDSR: drive status bits repeatedly, 8 bits per byte, until CS high.
  - WRSR: on the 8th rise, status[7:6] <= received[7:6]; status[5:0] stays 0. Remaining bits are ignored.
  - IGNORE: SO tri-stated, wait for CS high.
- Mode = status[7:6]:
  - 00 byte: after one data byte, the FSM -> IGNORE. Further bits have no effect.
  - 10 page: address low PAGE_W bits increment and wrap within the page; upper bits held.
  - 01 sequential: address increments modulo 2^ADDR_W (8191 -> 0).
  - 11: treated as byte mode.
- RAM access is never issued outside RD_DATA/WR_DATA prefetch/commit points.

Decomposition:
- Package x_23K640_pkg:
  - instruction opcodes (INS_READ/WRITE/RDSR/WRSR)
  - mode encodings (MODE_BYTE/PAGE/SEQ)
  - FSM state enum
- One sub-module, x_23K640_sync: 2-flop synchronizer for sck/cs/si plus SCK rise/fall strobe generation.

Test Plan:
- WRSR: CS low, send 0x01, 0x40, CS high -> o_status=8'h40, no o_mem_en pulses.
- Byte write: send 0x02, addr 0x0123, data 0xA5 -> exactly one o_mem_en/o_mem_we pulse with addr 0x0123, wdata 0xA5.
- Byte read: RAM[0x0123]=0xA5, send 0x03, 0x0123, clock 8 bits -> SO carries 1010_0101 MSB first, o_so_oe high only during those 8 bits.
- Sequential wrap:
  - status 0x40, write at 0x1FFF with data 0x11, 0x22 -> writes to 0x1FFF then 0x0000.
  - page mode (0x80) at 0x003F -> writes to 0x003F then 0x0020.
- Abort: CS high after 5 data bits of a write -> no RAM write; the next transaction decodes normally.
- Unknown opcode 0x9F followed by 24 clocks -> o_so_oe stays 0, no RAM access. Assert i_rst mid-read -> all outputs 0 immediately and status = 0x00.
